uart_tx_fifo_reader: RTL and testbench

Consumer end of the TX data FIFO. The block pops words from the FIFO's read port and serializes bits [7:0] of each word onto the UART tx line as start, data (LSB first), optional parity, then stop bits. It sits between the TX FIFO and the SoC's tx pad, next to the UART RX path that fills the RX FIFO.

---
 rtl/uart_tx_fifo_reader.sv | 154 +++++++++++++++
 tb/tb_uart_tx_fifo_reader.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo_reader.sv
// uart_tx_fifo_reader
//   Pops words from the TX FIFO read port and serializes bits [7:0] of each
//   word onto the UART tx line: start bit, 8 data bits LSB first, optional
//   parity bit, then STOP_BITS stop bits. Each bit lasts div_eff clocks.
//
// Ports
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   tx_en       allows a new frame to be popped (checked only in IDLE)
//   clkdiv      clocks per UART bit (0 is treated as 1), sampled per frame
//   fifo_empty  FIFO empty flag
//   fifo_valid  FIFO read-data valid, one cycle after an accepted pop
//   fifo_data   FIFO read data; only [7:0] is transmitted
//   fifo_rd_en  FIFO pop request (combinational, IDLE only)
//   tx          serial output, idle high
//   busy        high whenever the FSM is not in IDLE
//   tx_done     one-cycle pulse on the last cycle of the final stop bit
module uart_tx_fifo_reader #(
    parameter int FIFO_WIDTH = 32,
    parameter int DIV_WIDTH  = 16,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tx_en,
    input  logic [DIV_WIDTH-1:0]  clkdiv,
    input  logic                  fifo_empty,
    input  logic                  fifo_valid,
    input  logic [FIFO_WIDTH-1:0] fifo_data,
    output logic                  fifo_rd_en,
    output logic                  tx,
    output logic                  busy,
    output logic                  tx_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_DATA,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    state_e               state_q, state_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [7:0]           data_q, data_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic                 stop_idx_q, stop_idx_d;

    logic [DIV_WIDTH-1:0] div_eff;
    logic                 bit_end;
    logic                 last_stop;
    logic                 par_bit;
    logic                 unused_hi;

    assign div_eff   = (clkdiv == '0) ? DIV_WIDTH'(1) : clkdiv;
    assign bit_end   = (cnt_q == '0);
    assign last_stop = bit_end && (stop_idx_q == 1'(STOP_BITS - 1));
    // Even parity is the XOR of the data bits; odd parity inverts it.
    assign par_bit   = (^data_q) ^ (PARITY == 2);
    assign unused_hi = ^fifo_data[FIFO_WIDTH-1:8];

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (fifo_rd_en) state_d = S_WAIT_DATA;
            S_WAIT_DATA: if (fifo_valid) state_d = S_START;
            S_START:     if (bit_end)    state_d = S_DATA;
            S_DATA: begin
                if (bit_end && bit_idx_q == 3'd7)
                    state_d = (PARITY != 0) ? S_PARITY : S_STOP;
            end
            S_PARITY:    if (bit_end)    state_d = S_STOP;
            S_STOP:      if (last_stop)  state_d = S_IDLE;
            default:                     state_d = S_IDLE;
        endcase
    end

    // ---------------- outputs ----------------
    always_comb begin
        fifo_rd_en = 1'b0;
        tx         = 1'b1;
        busy       = (state_q != S_IDLE);
        tx_done    = 1'b0;
        case (state_q)
            // rst_n gating keeps the pop request low while reset is held.
            S_IDLE:   fifo_rd_en = rst_n && tx_en && !fifo_empty;
            S_START:  tx = 1'b0;
            S_DATA:   tx = data_q[bit_idx_q];
            S_PARITY: tx = par_bit;
            S_STOP:   tx_done = last_stop;
            default:  ;
        endcase
    end

    // ---------------- datapath: bit timer, indices, data ----------------
    always_comb begin
        div_d      = div_q;
        cnt_d      = cnt_q;
        data_d     = data_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        case (state_q)
            S_WAIT_DATA: begin
                // Divisor is captured here only, so clkdiv changes take
                // effect from the next frame.
                if (fifo_valid) begin
                    data_d     = fifo_data[7:0];
                    div_d      = div_eff;
                    cnt_d      = div_eff - DIV_WIDTH'(1);
                    bit_idx_d  = 3'd0;
                    stop_idx_d = 1'b0;
                end
            end
            S_START, S_DATA, S_PARITY, S_STOP: begin
                if (bit_end) begin
                    cnt_d = div_q - DIV_WIDTH'(1);
                    if (state_q == S_DATA) bit_idx_d  = bit_idx_q + 3'd1;
                    if (state_q == S_STOP) stop_idx_d = ~stop_idx_q;
                end else begin
                    cnt_d = cnt_q - DIV_WIDTH'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q      <= '0;
            cnt_q      <= '0;
            data_q     <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
        end else begin
            div_q      <= div_d;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo_reader.sv
// Directed bench for uart_tx_fifo_reader. Two instances share one FIFO
// model: dut (no parity, 1 stop) and dut_p (odd parity, 2 stop bits).
module tb_uart_tx_fifo_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tx_en, tx_en2;
    logic [15:0] clkdiv;
    logic        fifo_empty, fifo_valid;
    logic [31:0] fifo_data;
    logic        rd, tx, busy, done;
    logic        rd2, tx2, busy2, done2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_tx_fifo_reader dut (
        .clk(clk), .rst_n(rst_n), .tx_en(tx_en), .clkdiv(clkdiv),
        .fifo_empty(fifo_empty), .fifo_valid(fifo_valid), .fifo_data(fifo_data),
        .fifo_rd_en(rd), .tx(tx), .busy(busy), .tx_done(done)
    );

    uart_tx_fifo_reader #(.PARITY(2), .STOP_BITS(2)) dut_p (
        .clk(clk), .rst_n(rst_n), .tx_en(tx_en2), .clkdiv(clkdiv),
        .fifo_empty(fifo_empty), .fifo_valid(fifo_valid), .fifo_data(fifo_data),
        .fifo_rd_en(rd2), .tx(tx2), .busy(busy2), .tx_done(done2)
    );

    // FIFO model: valid/data one cycle after an accepted pop.
    logic [31:0] mem [0:15];
    int pushes = 0;
    int pops   = 0;
    assign fifo_empty = (pushes == pops);

    initial begin
        fifo_valid = 1'b0;
        fifo_data  = '0;
    end

    always @(posedge clk) begin
        fifo_valid <= 1'b0;
        if ((rd || rd2) && (pushes != pops)) begin
            fifo_data  <= mem[pops[3:0]];
            fifo_valid <= 1'b1;
            pops       <= pops + 1;
        end
    end

    task automatic push(input logic [31:0] w);
        mem[pushes[3:0]] = w;
        pushes++;
    endtask

    // Per-cycle capture of outputs (sampled at negedge).
    logic rec_tx [0:127];
    logic rec_bz [0:127];
    logic rec_dn [0:127];
    logic rec_rd [0:127];

    task automatic record(input int start, input int n, input bit sel);
        for (int i = start; i < start + n; i++) begin
            @(negedge clk);
            rec_tx[i] = sel ? tx2   : tx;
            rec_bz[i] = sel ? busy2 : busy;
            rec_dn[i] = sel ? done2 : done;
            rec_rd[i] = sel ? rd2   : rd;
        end
    endtask

    // Returns in the cycle where the pop request is high (sampled mid-cycle).
    task automatic wait_rd(input bit sel, input int lim, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < lim; i++) begin
            #1;
            if (sel ? rd2 : rd) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Reference line level for frame cycle f (0 = first start-bit cycle).
    function automatic logic exp_tx(input logic [7:0] b, input int div,
                                    input int par, input int f);
        int n;
        n = f / div;
        if (n == 0) return 1'b0;
        if (n <= 8) return b[n-1];
        if (n == 9 && par != 0) return (^b) ^ (par == 2);
        return 1'b1;
    endfunction

    task automatic test_reset;
        bit seen;
        rst_n = 1'b0; tx_en = 1'b1; tx_en2 = 1'b0; clkdiv = 16'd4;
        push(32'h0000_00A5);
        @(negedge clk);
        #1;
        checks++; if (tx !== 1'b1)   begin failures++; $display("FAIL reset_tx got %b exp 1", tx); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got %b exp 0", done); end
        checks++; if (rd !== 1'b0)   begin failures++; $display("FAIL reset_rd got %b exp 0", rd); end
        checks++; if (tx2 !== 1'b1)  begin failures++; $display("FAIL reset_tx2 got %b exp 1", tx2); end
        @(negedge clk);
        rst_n = 1'b1;
        wait_rd(1'b0, 5, seen);
        checks++; if (!seen) begin failures++; $display("FAIL reset_first_pop got 0 exp 1"); end
    endtask

    // Pop already seen in test_reset: byte 0xA5, div 4, 40-cycle frame.
    task automatic test_single;
        logic et, eb, ed;
        record(0, 43, 1'b0);
        for (int i = 0; i < 43; i++) begin
            eb = (i <= 40);
            ed = (i == 40);
            et = (i >= 1 && i <= 40) ? exp_tx(8'hA5, 4, 0, i - 1) : 1'b1;
            checks++; if (rec_tx[i] !== et) begin failures++; $display("FAIL single_tx[%0d] got %b exp %b", i, rec_tx[i], et); end
            checks++; if (rec_bz[i] !== eb) begin failures++; $display("FAIL single_busy[%0d] got %b exp %b", i, rec_bz[i], eb); end
            checks++; if (rec_dn[i] !== ed) begin failures++; $display("FAIL single_done[%0d] got %b exp %b", i, rec_dn[i], ed); end
            checks++; if (rec_rd[i] !== 1'b0) begin failures++; $display("FAIL single_rd[%0d] got %b exp 0", i, rec_rd[i]); end
        end
    endtask

    // Three queued words, div 2: 20-cycle frames, 22-cycle pop period.
    task automatic test_back_to_back;
        bit seen;
        int c, k, r, npop;
        logic et, eb, ed, er;
        logic [7:0] bs [0:2];
        bs[0] = 8'h11; bs[1] = 8'h22; bs[2] = 8'h33;
        clkdiv = 16'd2;
        push(32'hDEAD_BE11); push(32'h1234_5622); push(32'hFFFF_FF33);
        wait_rd(1'b0, 5, seen);
        checks++; if (!seen) begin failures++; $display("FAIL b2b_first_pop got 0 exp 1"); end
        record(0, 70, 1'b0);
        npop = 1;
        for (int i = 0; i < 70; i++) begin
            c = i + 1; k = c / 22; r = c % 22;
            et = 1'b1; eb = 1'b0; ed = 1'b0; er = 1'b0;
            if (k < 3) begin
                if (r == 0) er = 1'b1;
                else begin
                    eb = 1'b1;
                    if (r >= 2) begin
                        et = exp_tx(bs[k], 2, 0, r - 2);
                        ed = (r == 21);
                    end
                end
            end
            if (rec_rd[i] === 1'b1) npop++;
            checks++; if (rec_tx[i] !== et) begin failures++; $display("FAIL b2b_tx[%0d] got %b exp %b", i, rec_tx[i], et); end
            checks++; if (rec_bz[i] !== eb) begin failures++; $display("FAIL b2b_busy[%0d] got %b exp %b", i, rec_bz[i], eb); end
            checks++; if (rec_dn[i] !== ed) begin failures++; $display("FAIL b2b_done[%0d] got %b exp %b", i, rec_dn[i], ed); end
            checks++; if (rec_rd[i] !== er) begin failures++; $display("FAIL b2b_rd[%0d] got %b exp %b", i, rec_rd[i], er); end
        end
        checks++; if (npop != 3) begin failures++; $display("FAIL b2b_pops got %0d exp 3", npop); end
    endtask

    // Odd parity, 2 stop bits, byte 0x07, div 3: 12 bits x 3 = 36 cycles.
    task automatic test_parity;
        bit seen;
        logic et, eb, ed;
        tx_en = 1'b0; tx_en2 = 1'b1; clkdiv = 16'd3;
        push(32'hCAFE_0007);
        wait_rd(1'b1, 5, seen);
        checks++; if (!seen) begin failures++; $display("FAIL par_pop got 0 exp 1"); end
        record(0, 40, 1'b1);
        tx_en2 = 1'b0;
        for (int i = 0; i < 40; i++) begin
            eb = (i <= 36);
            ed = (i == 36);
            et = (i >= 1 && i <= 36) ? exp_tx(8'h07, 3, 2, i - 1) : 1'b1;
            checks++; if (rec_tx[i] !== et) begin failures++; $display("FAIL par_tx[%0d] got %b exp %b", i, rec_tx[i], et); end
            checks++; if (rec_bz[i] !== eb) begin failures++; $display("FAIL par_busy[%0d] got %b exp %b", i, rec_bz[i], eb); end
            checks++; if (rec_dn[i] !== ed) begin failures++; $display("FAIL par_done[%0d] got %b exp %b", i, rec_dn[i], ed); end
        end
        // Parity bit occupies frame cycles 27..29: odd parity of 0x07 is 0.
        checks++; if (rec_tx[28] !== 1'b0) begin failures++; $display("FAIL par_bit got %b exp 0", rec_tx[28]); end
    endtask

    // clkdiv = 0 behaves as 1: 10-cycle frame.
    task automatic test_div0;
        bit seen;
        logic et, eb, ed;
        tx_en = 1'b1; clkdiv = 16'd0;
        push(32'h0000_00FF);
        wait_rd(1'b0, 5, seen);
        checks++; if (!seen) begin failures++; $display("FAIL div0_pop got 0 exp 1"); end
        record(0, 12, 1'b0);
        for (int i = 0; i < 12; i++) begin
            eb = (i <= 10);
            ed = (i == 10);
            et = (i >= 1 && i <= 10) ? exp_tx(8'hFF, 1, 0, i - 1) : 1'b1;
            checks++; if (rec_tx[i] !== et) begin failures++; $display("FAIL div0_tx[%0d] got %b exp %b", i, rec_tx[i], et); end
            checks++; if (rec_bz[i] !== eb) begin failures++; $display("FAIL div0_busy[%0d] got %b exp %b", i, rec_bz[i], eb); end
            checks++; if (rec_dn[i] !== ed) begin failures++; $display("FAIL div0_done[%0d] got %b exp %b", i, rec_dn[i], ed); end
        end
    endtask

    // clkdiv 8 -> 2 mid-frame: frame 1 stays at 8/bit, frame 2 uses 2.
    task automatic test_div_change;
        bit seen;
        logic et, eb, ed, er;
        clkdiv = 16'd8;
        push(32'h0000_003C); push(32'h0000_005A);
        wait_rd(1'b0, 5, seen);
        checks++; if (!seen) begin failures++; $display("FAIL divchg_pop got 0 exp 1"); end
        record(0, 20, 1'b0);
        clkdiv = 16'd2;
        record(20, 86, 1'b0);
        for (int i = 0; i < 106; i++) begin
            et = 1'b1; eb = 1'b0; ed = 1'b0; er = 1'b0;
            if (i == 0 || i == 82) eb = 1'b1;
            else if (i <= 80) begin eb = 1'b1; et = exp_tx(8'h3C, 8, 0, i - 1); ed = (i == 80); end
            else if (i == 81) er = 1'b1;
            else if (i <= 102) begin eb = 1'b1; et = exp_tx(8'h5A, 2, 0, i - 83); ed = (i == 102); end
            checks++; if (rec_tx[i] !== et) begin failures++; $display("FAIL divchg_tx[%0d] got %b exp %b", i, rec_tx[i], et); end
            checks++; if (rec_bz[i] !== eb) begin failures++; $display("FAIL divchg_busy[%0d] got %b exp %b", i, rec_bz[i], eb); end
            checks++; if (rec_dn[i] !== ed) begin failures++; $display("FAIL divchg_done[%0d] got %b exp %b", i, rec_dn[i], ed); end
            checks++; if (rec_rd[i] !== er) begin failures++; $display("FAIL divchg_rd[%0d] got %b exp %b", i, rec_rd[i], er); end
        end
    endtask

    // Reset during data bit 3 of 0x96 (tx low there), then a fresh pop.
    task automatic test_reset_mid;
        bit seen;
        logic et, eb, ed;
        clkdiv = 16'd4;
        push(32'h0000_0096); push(32'h0000_0044);
        wait_rd(1'b0, 5, seen);
        checks++; if (!seen) begin failures++; $display("FAIL rstmid_pop got 0 exp 1"); end
        record(0, 18, 1'b0);
        for (int i = 1; i < 18; i++) begin
            et = exp_tx(8'h96, 4, 0, i - 1);
            checks++; if (rec_tx[i] !== et) begin failures++; $display("FAIL rstmid_pre_tx[%0d] got %b exp %b", i, rec_tx[i], et); end
            checks++; if (rec_dn[i] !== 1'b0) begin failures++; $display("FAIL rstmid_pre_done[%0d] got %b exp 0", i, rec_dn[i]); end
        end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (tx !== 1'b1)   begin failures++; $display("FAIL rstmid_tx got %b exp 1", tx); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got %b exp 0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL rstmid_done got %b exp 0", done); end
        @(negedge clk);
        #1;
        checks++; if (rd !== 1'b0) begin failures++; $display("FAIL rstmid_rd_in_reset got %b exp 0", rd); end
        @(negedge clk);
        rst_n = 1'b1;
        wait_rd(1'b0, 5, seen);
        checks++; if (!seen) begin failures++; $display("FAIL rstmid_fresh_pop got 0 exp 1"); end
        record(0, 42, 1'b0);
        for (int i = 0; i < 42; i++) begin
            eb = (i <= 40);
            ed = (i == 40);
            et = (i >= 1 && i <= 40) ? exp_tx(8'h44, 4, 0, i - 1) : 1'b1;
            checks++; if (rec_tx[i] !== et) begin failures++; $display("FAIL rstmid_tx[%0d] got %b exp %b", i, rec_tx[i], et); end
            checks++; if (rec_bz[i] !== eb) begin failures++; $display("FAIL rstmid_busy[%0d] got %b exp %b", i, rec_bz[i], eb); end
            checks++; if (rec_dn[i] !== ed) begin failures++; $display("FAIL rstmid_done[%0d] got %b exp %b", i, rec_dn[i], ed); end
        end
    endtask

    // tx_en low holds off pops; dropping it during START finishes the frame.
    task automatic test_tx_en;
        bit seen;
        logic et, eb, ed;
        tx_en = 1'b0; clkdiv = 16'd2;
        push(32'h0000_0055); push(32'h0000_0066);
        record(0, 50, 1'b0);
        for (int i = 0; i < 50; i++) begin
            checks++; if (rec_rd[i] !== 1'b0) begin failures++; $display("FAIL txen_hold_rd[%0d] got %b exp 0", i, rec_rd[i]); end
            checks++; if (rec_tx[i] !== 1'b1) begin failures++; $display("FAIL txen_hold_tx[%0d] got %b exp 1", i, rec_tx[i]); end
        end
        tx_en = 1'b1;
        wait_rd(1'b0, 5, seen);
        checks++; if (!seen) begin failures++; $display("FAIL txen_pop got 0 exp 1"); end
        record(0, 2, 1'b0);
        tx_en = 1'b0;
        record(2, 60, 1'b0);
        for (int i = 0; i < 62; i++) begin
            eb = (i <= 20);
            ed = (i == 20);
            et = (i >= 1 && i <= 20) ? exp_tx(8'h55, 2, 0, i - 1) : 1'b1;
            checks++; if (rec_tx[i] !== et) begin failures++; $display("FAIL txen_tx[%0d] got %b exp %b", i, rec_tx[i], et); end
            checks++; if (rec_bz[i] !== eb) begin failures++; $display("FAIL txen_busy[%0d] got %b exp %b", i, rec_bz[i], eb); end
            checks++; if (rec_dn[i] !== ed) begin failures++; $display("FAIL txen_done[%0d] got %b exp %b", i, rec_dn[i], ed); end
            checks++; if (rec_rd[i] !== 1'b0) begin failures++; $display("FAIL txen_rd[%0d] got %b exp 0", i, rec_rd[i]); end
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_back_to_back;
        test_parity;
        test_div0;
        test_div_change;
        test_reset_mid;
        test_tx_en;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
